mux8_scan_ctrl: RTL and testbench

- Sequencer for a shared 8:1 single-bit mux (3 select bits, 8 data bits, 1 output).
- Drives the mux select through the unmasked inputs in ascending order and waits a programmable settle time per input.
- Samples the mux output for each input and assembles an 8-bit word.
- Delivers the word on a valid/ready handshake, in one-shot or continuous mode.

---
 rtl/mux8_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mux8_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_scan_ctrl.sv
// mux8_scan_ctrl: walks a shared 8:1 mux through the unmasked inputs in
// ascending order, waits SETTLE cycles per input, samples each one into a
// word and hands the word out on a valid/ready handshake.
module mux8_scan_ctrl #(
   parameter int unsigned SETTLE = 1,
   parameter int unsigned CNT_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             cont,
   input  logic             abort,
   input  logic [7:0]       mask,
   output logic [2:0]       mux_sel,
   input  logic             mux_out,
   output logic [7:0]       word,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // Last value of the settle counter before moving on to SAMPLE.
   localparam logic [3:0] SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
   // State entered for each visited input: SETTLE=0 skips straight to SAMPLE.
   localparam state_t FIRST_ST = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;

   state_t           state_q, state_d;
   logic [2:0]       sel_q, sel_d;
   logic [7:0]       word_q, word_d;
   logic [7:0]       mask_q, mask_d;
   logic [3:0]       settle_q, settle_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             hs_s;
   logic [3:0]       launch_s;
   logic [3:0]       next_s;

   // Lowest index >= lo whose mask bit is clear; result is {found, index}.
   function automatic logic [3:0] first_free(input logic [7:0] m, input logic [3:0] lo);
      logic [3:0] r;
      r = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         r = ((4'(i) >= lo) && !m[i]) ? {1'b1, 3'(i)} : r;
      end
      return r;
   endfunction

   assign hs_s     = valid_q & word_ready;
   // A new scan latches mask on the same edge, so it is evaluated on the live input.
   assign launch_s = first_free(mask, 4'd0);
   assign next_s   = first_free(mask_q, {1'b0, sel_q} + 4'd1);

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sel_q    <= 3'd0;
         word_q   <= 8'd0;
         mask_q   <= 8'd0;
         settle_q <= 4'd0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         word_q   <= word_d;
         mask_q   <= mask_d;
         settle_q <= settle_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state and datapath logic; abort overrides everything, including a handshake.
   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      word_d   = word_q;
      mask_d   = mask_q;
      settle_d = settle_q;
      valid_d  = 1'b0;
      cnt_d    = cnt_q;

      if (abort) begin
         state_d  = ST_IDLE;
         word_d   = 8'd0;
         settle_d = 4'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mask_d   = mask;
                  word_d   = 8'd0;
                  settle_d = 4'd0;
                  if (launch_s[3]) begin
                     sel_d   = launch_s[2:0];
                     state_d = FIRST_ST;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  settle_d = 4'd0;
                  state_d  = ST_SAMPLE;
               end else begin
                  settle_d = settle_q + 4'd1;
               end
            end
            ST_SAMPLE: begin
               word_d[sel_q] = mux_out;
               if (next_s[3]) begin
                  sel_d   = next_s[2:0];
                  state_d = FIRST_ST;
               end else begin
                  state_d = ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (hs_s) begin
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cont) begin
                     mask_d   = mask;
                     word_d   = 8'd0;
                     settle_d = 4'd0;
                     if (launch_s[3]) begin
                        sel_d   = launch_s[2:0];
                        state_d = FIRST_ST;
                     end else begin
                        state_d = ST_HOLD;
                     end
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  // Valid rises one cycle after HOLD is entered and stays up until taken.
                  valid_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign mux_sel    = sel_q;
   assign word       = word_q;
   assign word_valid = valid_q;
   assign busy       = busy_q;
   assign word_cnt   = cnt_q;

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: one instance with SETTLE=1, one with SETTLE=0.
module tb_mux8_scan_ctrl;

   logic       clk;
   logic       rst;
   logic       start1, start0;
   logic       cont;
   logic       abort;
   logic [7:0] mask;
   logic       word_ready;
   logic [7:0] data1, data0;

   logic [2:0] sel1, sel0;
   logic       mux_out1, mux_out0;
   logic [7:0] word1, word0;
   logic       valid1, valid0;
   logic       busy1, busy0;
   logic [7:0] cnt1, cnt0;

   int checks;
   int errors;

   // The shared mux is modelled by the bench: output is the selected bit of the data pattern.
   assign mux_out1 = data1[sel1];
   assign mux_out0 = data0[sel0];

   mux8_scan_ctrl #(.SETTLE(1), .CNT_W(8)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .cont(cont), .abort(abort), .mask(mask),
      .mux_sel(sel1), .mux_out(mux_out1), .word(word1), .word_valid(valid1),
      .word_ready(word_ready), .busy(busy1), .word_cnt(cnt1)
   );

   mux8_scan_ctrl #(.SETTLE(0), .CNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .cont(1'b0), .abort(1'b0), .mask(mask),
      .mux_sel(sel0), .mux_out(mux_out0), .word(word0), .word_valid(valid0),
      .word_ready(word_ready), .busy(busy0), .word_cnt(cnt0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start1();
      start1 = 1'b1;
      cyc();
      start1 = 1'b0;
   endtask

   task automatic pulse_start0();
      start0 = 1'b1;
      cyc();
      start0 = 1'b0;
   endtask

   // Cycles after the start edge until valid rises; -1 if it never does.
   task automatic wait_valid1(input int maxc, output int lat);
      lat = -1;
      for (int k = 1; k <= maxc; k++) begin
         cyc();
         if (valid1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic wait_valid0(input int maxc, output int lat);
      lat = -1;
      for (int k = 1; k <= maxc; k++) begin
         cyc();
         if (valid0) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int bad;
      int n;
      int maxsel;
      logic prev_valid;

      checks = 0;
      errors = 0;
      rst = 1'b1; start1 = 1'b0; start0 = 1'b0; cont = 1'b0; abort = 1'b0;
      mask = 8'h00; word_ready = 1'b0; data1 = 8'h00; data0 = 8'h00;

      // Reset state
      cyc(); cyc();
      check_val("rst_sel",   {29'd0, sel1}, 32'd0);
      check_val("rst_word",  {24'd0, word1}, 32'd0);
      check_val("rst_valid", {31'd0, valid1}, 32'd0);
      check_val("rst_busy",  {31'd0, busy1}, 32'd0);
      check_val("rst_cnt",   {24'd0, cnt1}, 32'd0);
      rst = 1'b0;
      cyc();

      // 1: full scan of 0xA5, SETTLE=1
      data1 = 8'hA5; mask = 8'h00; word_ready = 1'b1;
      pulse_start1();
      bad = 0;
      lat = -1;
      if (sel1 !== 3'd0) bad++;
      for (int k = 1; k <= 40; k++) begin
         cyc();
         if (valid1) begin
            lat = k;
            break;
         end
         if (sel1 !== 3'((k / 2 > 7) ? 7 : k / 2)) bad++;
      end
      check_val("t1_sel_walk", bad, 0);
      check_val("t1_latency", lat, 17);
      check_val("t1_word", {24'd0, word1}, 32'h0A5);
      check_val("t1_cnt_pre", {24'd0, cnt1}, 32'd0);
      cyc();
      check_val("t1_cnt", {24'd0, cnt1}, 32'd1);
      check_val("t1_valid_drop", {31'd0, valid1}, 32'd0);
      check_val("t1_busy_drop", {31'd0, busy1}, 32'd0);

      // 2: SETTLE=0, mask 0xF0 then 0xFF
      data0 = 8'hFF; mask = 8'hF0;
      pulse_start0();
      maxsel = 0;
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         if (int'(sel0) > maxsel) maxsel = int'(sel0);
         cyc();
         if (valid0) begin
            lat = k;
            break;
         end
      end
      check_val("t2_latency", lat, 5);
      check_val("t2_maxsel", maxsel, 3);
      check_val("t2_word", {24'd0, word0}, 32'h00F);
      cyc();
      mask = 8'hFF;
      pulse_start0();
      wait_valid0(10, lat);
      check_val("t2_allmask_lat", lat, 1);
      check_val("t2_allmask_word", {24'd0, word0}, 32'd0);
      cyc();
      check_val("t2_cnt", {24'd0, cnt0}, 32'd2);

      // 3: backpressure in HOLD (unmasked 0,1,6,7 of 0x5A -> 0x42)
      word_ready = 1'b0; mask = 8'h3C; data1 = 8'h5A;
      pulse_start1();
      wait_valid1(40, lat);
      check_val("t3_latency", lat, 9);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         if (word1 !== 8'h42 || valid1 !== 1'b1 || cnt1 !== 8'd1) bad++;
         cyc();
      end
      check_val("t3_stable", bad, 0);
      word_ready = 1'b1;
      cyc();
      check_val("t3_cnt", {24'd0, cnt1}, 32'd2);
      check_val("t3_valid_drop", {31'd0, valid1}, 32'd0);

      // 4: continuous mode, 300 words, counter wraps (mask 0xF0 of 0xA5 -> 0x05)
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      mask = 8'hF0; data1 = 8'hA5; cont = 1'b1; word_ready = 1'b1;
      pulse_start1();
      mask = 8'h0F;            // ignored: mask is re-sampled only at each restart
      mask = 8'hF0;
      n = 0; bad = 0; prev_valid = 1'b0;
      for (int k = 0; k < 8000; k++) begin
         cyc();
         if (prev_valid && valid1) bad++;
         if (valid1) begin
            if (word1 !== 8'h05 || cnt1 !== 8'(n)) bad++;
            if (n == 256) check_val("t4_wrap", {24'd0, cnt1}, 32'd0);
            n++;
            if (n == 300) cont = 1'b0;
         end
         prev_valid = valid1;
         if (n == 300) break;
      end
      cyc(); cyc();
      check_val("t4_words", n, 300);
      check_val("t4_bad", bad, 0);
      check_val("t4_cnt", {24'd0, cnt1}, 32'd44);
      check_val("t4_idle", {31'd0, busy1}, 32'd0);

      // 5: abort in the third SETTLE
      mask = 8'h00; data1 = 8'hA5;
      pulse_start1();
      for (int k = 0; k < 4; k++) cyc();
      check_val("t5_sel_at_abort", {29'd0, sel1}, 32'd2);
      check_val("t5_busy_at_abort", {31'd0, busy1}, 32'd1);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      check_val("t5_busy", {31'd0, busy1}, 32'd0);
      check_val("t5_word", {24'd0, word1}, 32'd0);
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         if (valid1) bad++;
         cyc();
      end
      check_val("t5_no_valid", bad, 0);
      check_val("t5_cnt", {24'd0, cnt1}, 32'd44);
      data1 = 8'h3C;
      pulse_start1();
      wait_valid1(40, lat);
      check_val("t5_restart_lat", lat, 17);
      check_val("t5_restart_word", {24'd0, word1}, 32'h03C);
      cyc();
      check_val("t5_restart_cnt", {24'd0, cnt1}, 32'd45);

      // 6: asynchronous reset between edges during SAMPLE
      data1 = 8'hFF;
      pulse_start1();
      for (int k = 0; k < 5; k++) cyc();
      check_val("t6_pre_word", {24'd0, word1}, 32'h003);
      #2;
      rst = 1'b1;
      start1 = 1'b1;
      #1;
      check_val("t6_sel",   {29'd0, sel1}, 32'd0);
      check_val("t6_word",  {24'd0, word1}, 32'd0);
      check_val("t6_valid", {31'd0, valid1}, 32'd0);
      check_val("t6_busy",  {31'd0, busy1}, 32'd0);
      check_val("t6_cnt",   {24'd0, cnt1}, 32'd0);
      cyc(); cyc();
      check_val("t6_start_ignored", {31'd0, busy1}, 32'd0);
      rst = 1'b0;
      start1 = 1'b0;
      cyc();
      check_val("t6_after_rel", {31'd0, busy1}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
